// File: rtl/prescaler_pkg.sv
// Shared constants for the timer prescaler: clock-select codes, tap indices,
// and the per-channel clock-select decode.
package prescaler_pkg;

    localparam int CS_W     = 3;
    localparam int NUM_TAPS = 4;

    localparam logic [CS_W-1:0] CS_STOP     = 3'd0;
    localparam logic [CS_W-1:0] CS_CLK      = 3'd1;
    localparam logic [CS_W-1:0] CS_DIV8     = 3'd2;
    localparam logic [CS_W-1:0] CS_DIV64    = 3'd3;
    localparam logic [CS_W-1:0] CS_DIV256   = 3'd4;
    localparam logic [CS_W-1:0] CS_DIV1024  = 3'd5;
    localparam logic [CS_W-1:0] CS_EXT_FALL = 3'd6;
    localparam logic [CS_W-1:0] CS_EXT_RISE = 3'd7;

    localparam int TAP_DIV8    = 0;
    localparam int TAP_DIV64   = 1;
    localparam int TAP_DIV256  = 2;
    localparam int TAP_DIV1024 = 3;

    function automatic logic cs_select(input logic [CS_W-1:0]     cs,
                                       input logic [NUM_TAPS-1:0] taps,
                                       input logic                rise,
                                       input logic                fall);
        logic en;
        en = 1'b0;
        case (cs)
            CS_STOP:     en = 1'b0;
            CS_CLK:      en = 1'b1;
            CS_DIV8:     en = taps[TAP_DIV8];
            CS_DIV64:    en = taps[TAP_DIV64];
            CS_DIV256:   en = taps[TAP_DIV256];
            CS_DIV1024:  en = taps[TAP_DIV1024];
            CS_EXT_FALL: en = fall;
            CS_EXT_RISE: en = rise;
            default:     en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ext_edge_sync.sv
// Synchronises one asynchronous Tn pin and produces single-cycle rise/fall
// pulses from the synchronised level.
module ext_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/prescaler_sync_mux.sv
// Shared timer prescaler: free-running counter with /8../1024 taps, PSRSYNC/TSM
// hold, and a per-channel clock-select mux over taps and external pin edges.
module prescaler_sync_mux
    import prescaler_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   psr_req,
    input  logic                   tsm,
    input  logic [CS_W*NUM_CH-1:0] cs,
    input  logic [NUM_CH-1:0]      ext_pin,
    output logic                   psr_flag,
    output logic [NUM_TAPS-1:0]    tap_en,
    output logic [NUM_CH-1:0]      clk_en
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             psr_flag_q, psr_flag_d;

    // While the flag is set the counter is parked at 0, so counting restarts
    // from 0 on the first edge after the flag clears.
    always_comb begin
        cnt_d      = psr_flag_q ? '0 : cnt_q + 1'b1;
        psr_flag_d = psr_req | (psr_flag_q & tsm);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            psr_flag_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            psr_flag_q <= psr_flag_d;
        end
    end

    assign psr_flag = psr_flag_q;

    always_comb begin
        tap_en              = '0;
        tap_en[TAP_DIV8]    = &cnt_q[2:0];
        tap_en[TAP_DIV64]   = &cnt_q[5:0];
        tap_en[TAP_DIV256]  = &cnt_q[7:0];
        tap_en[TAP_DIV1024] = &cnt_q[9:0];
        if (psr_flag_q)
            tap_en = '0;
    end

    logic [NUM_CH-1:0] ext_rise, ext_fall;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ext_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ext_sync (
            .clk  (clk),
            .reset(reset),
            .pin  (ext_pin[g]),
            .rise (ext_rise[g]),
            .fall (ext_fall[g])
        );

        assign clk_en[g] = cs_select(cs[CS_W*g +: CS_W], tap_en, ext_rise[g], ext_fall[g]);
    end

endmodule

// File: tb/tb_prescaler_sync_mux.sv
// Scoreboard bench for prescaler_sync_mux: the stimulus process pushes the
// expected per-cycle outputs; a monitor pops and compares them each cycle.
module tb_prescaler_sync_mux;

    localparam int NUM_CH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       psr_req = 1'b0;
    logic       tsm = 1'b0;
    logic [5:0] cs = '0;
    logic [1:0] ext_pin = '0;
    logic       psr_flag;
    logic [3:0] tap_en;
    logic [1:0] clk_en;

    prescaler_sync_mux #(.NUM_CH(NUM_CH), .CNT_W(10), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .psr_req(psr_req), .tsm(tsm), .cs(cs),
        .ext_pin(ext_pin), .psr_flag(psr_flag), .tap_en(tap_en), .clk_en(clk_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flag;
        logic [3:0] tap;
        logic [1:0] en;
        bit         care;
        int         test;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   test_id = 0;

    // Spec-level model state: counter value and PSRSYNC flag.
    logic [9:0] m_cnt  = '0;
    logic       m_flag = 1'b0;

    function automatic logic sel(input logic [2:0] c, input logic [3:0] t,
                                 input logic r, input logic f);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return t[0];
            3'd3: return t[1];
            3'd4: return t[2];
            3'd5: return t[3];
            3'd6: return f;
            default: return r;
        endcase
    endfunction

    task automatic tick(input logic [1:0] rise_e, input logic [1:0] fall_e, input bit care);
        exp_t       e;
        logic [3:0] t;
        t = m_flag ? 4'b0000 : {m_cnt == 10'h3FF, m_cnt[7:0] == 8'hFF,
                                m_cnt[5:0] == 6'h3F, m_cnt[2:0] == 3'h7};
        e.flag = m_flag;
        e.tap  = t;
        e.en[0] = sel(cs[2:0], t, rise_e[0], fall_e[0]);
        e.en[1] = sel(cs[5:3], t, rise_e[1], fall_e[1]);
        e.care = care;
        e.test = test_id;
        e.cyc  = cyc_n;
        exp_q.push_back(e);
        cyc_n++;
        if (reset) begin
            m_cnt  = '0;
            m_flag = 1'b0;
        end else begin
            m_cnt  = m_flag ? 10'd0 : m_cnt + 10'd1;
            m_flag = psr_req | (m_flag & tsm);
        end
        @(negedge clk);
    endtask

    // Monitor: outputs settle after the posedge and the negedge input update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    checks++;
                    if ({psr_flag, tap_en, clk_en} !== {e.flag, e.tap, e.en}) begin
                        errors++;
                        $display("FAIL test%0d cyc=%0d: got flag=%b tap=%b en=%b, expected flag=%b tap=%b en=%b",
                                 e.test, e.cyc, psr_flag, tap_en, clk_en, e.flag, e.tap, e.en);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Reset state.
        test_id = 0;
        tick(2'b00, 2'b00, 1'b0);
        cs = {3'd7, 3'd2};
        tick(2'b00, 2'b00, 1'b1);
        tick(2'b00, 2'b00, 1'b1);

        // 1: /8 on ch0, constant clock on ch1; covers first /1024 tap at 1023.
        test_id = 1;
        reset = 1'b0;
        cs = {3'd1, 3'd2};
        repeat (1100) tick(2'b00, 2'b00, 1'b1);

        // 2: prescaler reset at count 500 restarts the /1024 period.
        test_id = 2;
        cs = {3'd1, 3'd5};
        while (m_cnt != 10'd500) tick(2'b00, 2'b00, 1'b1);
        psr_req = 1'b1;
        tick(2'b00, 2'b00, 1'b1);
        psr_req = 1'b0;
        repeat (1100) tick(2'b00, 2'b00, 1'b1);

        // 3: TSM holds the flag and freezes the counter.
        test_id = 3;
        cs = {3'd4, 3'd2};
        tsm = 1'b1;
        psr_req = 1'b1;
        tick(2'b00, 2'b00, 1'b1);
        psr_req = 1'b0;
        repeat (100) tick(2'b00, 2'b00, 1'b1);
        tsm = 1'b0;
        repeat (20) tick(2'b00, 2'b00, 1'b1);

        // 4: external pin edges on ch1, rise then fall selection.
        test_id = 4;
        for (int j = 0; j < 25; j++) begin
            ext_pin[1] = ((j < 6) || (j >= 12 && j < 18));
            cs = {(j < 10) ? 3'd7 : 3'd6, 3'd3};
            tick({((j == 2) || (j == 14)), 1'b0}, {((j == 8) || (j == 20)), 1'b0}, 1'b1);
        end

        // 5: reset mid-count with the flag set.
        test_id = 5;
        cs = {3'd4, 3'd2};
        while (m_cnt != 10'd299) tick(2'b00, 2'b00, 1'b1);
        psr_req = 1'b1;
        tick(2'b00, 2'b00, 1'b1);
        psr_req = 1'b0;
        reset = 1'b1;
        tick(2'b00, 2'b00, 1'b1);
        cs = {3'd3, 3'd2}; tick(2'b00, 2'b00, 1'b1);
        cs = {3'd5, 3'd4}; tick(2'b00, 2'b00, 1'b1);
        cs = {3'd7, 3'd6}; tick(2'b00, 2'b00, 1'b1);
        cs = {3'd0, 3'd1}; tick(2'b00, 2'b00, 1'b1);
        reset = 1'b0;

        // 6: stop, then switch to constant clock mid-run.
        test_id = 6;
        cs = {3'd2, 3'd0};
        repeat (1000) tick(2'b00, 2'b00, 1'b1);
        cs = {3'd2, 3'd1};
        repeat (1048) tick(2'b00, 2'b00, 1'b1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
